// File: rtl/matmul_rf_pkg.sv
// Shared definitions for the matmul register file: region codes, control layout,
// status bit positions, FSM encoding and saturation limits.
package matmul_rf_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_A      = 3'd1;
   localparam logic [2:0] REG_B      = 3'd2;
   localparam logic [2:0] REG_FLAGS  = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;
   localparam logic [2:0] REG_SP     = 3'd5;

   localparam int unsigned CTRL_W = 16;

   localparam int unsigned ST_BUSY = 0;
   localparam int unsigned ST_DONE = 1;
   localparam int unsigned ST_ERR  = 2;
   localparam int unsigned ST_FLAG = 3;

   typedef struct packed {
      logic [7:0] rsvd;
      logic       clr;
      logic       sat;
      logic [1:0] src;
      logic [1:0] tgt;
      logic       acc;
      logic       start;
   } ctrl_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      WRITEBACK = 2'd2
   } state_e;

   // Most-positive (neg=0) or most-negative (neg=1) two's-complement value of a given width.
   function automatic logic [63:0] sat_limit(input int unsigned width, input logic neg);
      logic [63:0] msb;
      msb = 64'd1 << (width - 1);
      return neg ? msb : (msb - 64'd1);
   endfunction

endpackage

// File: rtl/matmul_rf_sat_add.sv
// Signed add with overflow detect and optional clamp to the signed range.
module matmul_rf_sat_add
   import matmul_rf_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sat,
   output logic [W-1:0] sum_c,
   output logic         ovf_c
);

   logic [W-1:0] raw_c;

   always_comb begin
      raw_c = a + b;
      ovf_c = (a[W-1] == b[W-1]) && (raw_c[W-1] != a[W-1]);
      sum_c = raw_c;
      if (ovf_c && sat) sum_c = W'(sat_limit(W, a[W-1]));
   end

endmodule

// File: rtl/matmul_regfile_seq.sv
// Register file between the APB slave and the matmul array: operands, control/status,
// overflow flags, scratchpads and a row-serial writeback of captured results.
module matmul_regfile_seq
   import matmul_rf_pkg::*;
#(
   parameter  int unsigned BUS_WIDTH      = 32,
   parameter  int unsigned DATA_WIDTH     = 8,
   parameter  int unsigned MAX_DIM        = 4,
   parameter  int unsigned SP_NTARGETS    = 4,
   localparam int unsigned IDX_W          = $clog2(MAX_DIM),
   localparam int unsigned TGT_W          = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
   localparam int unsigned LOC_ADDR_WIDTH = 5 + 2*IDX_W + TGT_W,
   localparam int unsigned LANES          = BUS_WIDTH / DATA_WIDTH,
   localparam int unsigned NELEM          = MAX_DIM * MAX_DIM
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            write_enable,
   input  logic [LOC_ADDR_WIDTH-1:0]       address,
   input  logic [BUS_WIDTH-1:0]            data_in,
   input  logic [LANES-1:0]                pstrb_i,
   output logic [BUS_WIDTH-1:0]            data_out,
   input  logic                            done_i,
   input  logic [NELEM*BUS_WIDTH-1:0]      res_i,
   input  logic [NELEM-1:0]                ouflow_i,
   output logic [NELEM*DATA_WIDTH-1:0]     a_row_o,
   output logic [NELEM*DATA_WIDTH-1:0]     b_col_o,
   output logic                            start_bit,
   output logic                            busy_o,
   output logic                            irq_o,
   output logic                            wr_err_o
);

   state_e                 state_q, state_d;
   ctrl_t                  ctrl_q, wr_ctrl_c, ctrl_store_c;
   logic [DATA_WIDTH-1:0]  a_q   [MAX_DIM][MAX_DIM];
   logic [DATA_WIDTH-1:0]  b_q   [MAX_DIM][MAX_DIM];
   logic [BUS_WIDTH-1:0]   sp_q  [SP_NTARGETS][MAX_DIM][MAX_DIM];
   logic [BUS_WIDTH-1:0]   buf_q [MAX_DIM][MAX_DIM];
   logic [MAX_DIM-1:0]     buf_ovf_q [MAX_DIM];
   logic [MAX_DIM-1:0]     flag_q    [MAX_DIM];
   logic [IDX_W-1:0]       row_q;
   logic                   done_q, err_q;

   logic [2:0]             region_c;
   logic [IDX_W-1:0]       row_c, col_c;
   logic [TGT_W-1:0]       tgt_c, wb_tgt_c, wb_src_c;
   logic                   ctrl_wr_c, a_wr_c, b_wr_c, sp_wr_c, prot_wr_c, idx_ok_c;
   logic                   accept_c, range_err_c, spurious_done_c, capture_c, wb_c;
   logic                   start_d, irq_d, wr_err_d, busy_d;
   logic [NELEM-1:0]       flags_c;
   logic [BUS_WIDTH-1:0]   acc_op_c  [MAX_DIM];
   logic [BUS_WIDTH-1:0]   wb_sum_c  [MAX_DIM];
   logic [MAX_DIM-1:0]     wb_ovf_c;
   logic                   unused_addr_c;

   assign region_c      = address[4:2];
   assign row_c         = address[5 +: IDX_W];
   assign col_c         = address[5+IDX_W +: IDX_W];
   assign tgt_c         = address[5+2*IDX_W +: TGT_W];
   assign unused_addr_c = ^address[1:0];

   assign wr_ctrl_c = ctrl_t'(data_in[CTRL_W-1:0]);
   assign ctrl_wr_c = write_enable && (region_c == REG_CTRL);
   assign a_wr_c    = write_enable && (region_c == REG_A);
   assign b_wr_c    = write_enable && (region_c == REG_B);
   assign sp_wr_c   = write_enable && (region_c == REG_SP) && (32'(tgt_c) < SP_NTARGETS);
   assign prot_wr_c = ctrl_wr_c || a_wr_c || b_wr_c;
   assign idx_ok_c  = (32'(wr_ctrl_c.tgt) < SP_NTARGETS) && (32'(wr_ctrl_c.src) < SP_NTARGETS);
   assign wb_tgt_c  = TGT_W'(ctrl_q.tgt);
   assign wb_src_c  = TGT_W'(ctrl_q.src);

   always_comb begin
      ctrl_store_c       = wr_ctrl_c;
      ctrl_store_c.start = 1'b0;
   end

   // Next-state and next-value of the registered strobes.
   always_comb begin
      state_d         = state_q;
      start_d         = 1'b0;
      irq_d           = 1'b0;
      wr_err_d        = 1'b0;
      accept_c        = 1'b0;
      range_err_c     = 1'b0;
      spurious_done_c = 1'b0;
      capture_c       = 1'b0;
      wb_c            = 1'b0;
      case (state_q)
         IDLE: begin
            spurious_done_c = done_i;
            if (ctrl_wr_c && wr_ctrl_c.start) begin
               if (idx_ok_c) begin
                  accept_c = 1'b1;
                  start_d  = 1'b1;
                  state_d  = BUSY;
               end else begin
                  range_err_c = 1'b1;
                  wr_err_d    = 1'b1;
               end
            end
         end
         BUSY: begin
            wr_err_d = prot_wr_c;
            if (done_i) begin
               capture_c = 1'b1;
               state_d   = WRITEBACK;
            end
         end
         WRITEBACK: begin
            wr_err_d        = prot_wr_c;
            spurious_done_c = done_i;
            wb_c            = 1'b1;
            if (row_q == IDX_W'(MAX_DIM - 1)) begin
               irq_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         start_bit <= 1'b0;
         irq_o     <= 1'b0;
         wr_err_o  <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_bit <= start_d;
         irq_o     <= irq_d;
         wr_err_o  <= wr_err_d;
         busy_o    <= busy_d;
      end
   end

   // Row-parallel writeback adders; source scratchpad read before the same-cycle write.
   always_comb begin
      for (int j = 0; j < MAX_DIM; j++)
         acc_op_c[j] = ctrl_q.acc ? sp_q[wb_src_c][row_q][j] : '0;
   end

   for (genvar j = 0; j < MAX_DIM; j++) begin : g_add
      matmul_rf_sat_add #(.W(BUS_WIDTH)) u_add (
         .a     (acc_op_c[j]),
         .b     (buf_q[row_q][j]),
         .sat   (ctrl_q.sat),
         .sum_c (wb_sum_c[j]),
         .ovf_c (wb_ovf_c[j])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         row_q  <= '0;
         for (int i = 0; i < MAX_DIM; i++) begin
            buf_ovf_q[i] <= '0;
            flag_q[i]    <= '0;
            for (int j = 0; j < MAX_DIM; j++) begin
               a_q[i][j]   <= '0;
               b_q[i][j]   <= '0;
               buf_q[i][j] <= '0;
               for (int t = 0; t < SP_NTARGETS; t++) sp_q[t][i][j] <= '0;
            end
         end
      end else begin
         if (ctrl_wr_c && state_q == IDLE) begin
            ctrl_q <= ctrl_store_c;
            if (wr_ctrl_c.start) begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
            end
         end
         if (range_err_c || spurious_done_c) err_q <= 1'b1;
         if (irq_d) done_q <= 1'b1;
         if (accept_c && wr_ctrl_c.clr) begin
            for (int i = 0; i < MAX_DIM; i++) flag_q[i] <= '0;
         end
         for (int i = 0; i < MAX_DIM; i++) begin
            if (a_wr_c && state_q == IDLE && pstrb_i[i]) a_q[row_c][i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            if (b_wr_c && state_q == IDLE && pstrb_i[i]) b_q[row_c][i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (sp_wr_c) sp_q[tgt_c][row_c][col_c] <= data_in;
         if (capture_c) begin
            row_q <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
               buf_ovf_q[i] <= ouflow_i[i*MAX_DIM +: MAX_DIM];
               for (int j = 0; j < MAX_DIM; j++)
                  buf_q[i][j] <= res_i[BUS_WIDTH*(MAX_DIM*i+j) +: BUS_WIDTH];
            end
         end
         if (wb_c) begin
            row_q <= row_q + 1'b1;
            for (int j = 0; j < MAX_DIM; j++) begin
               sp_q[wb_tgt_c][row_q][j] <= wb_sum_c[j];
               flag_q[row_q][j]         <= buf_ovf_q[row_q][j] | (ctrl_q.acc & wb_ovf_c[j]);
            end
         end
      end
   end

   // Continuous operand views and combinational read mux.
   always_comb begin
      for (int i = 0; i < MAX_DIM; i++) begin
         for (int j = 0; j < MAX_DIM; j++) begin
            a_row_o[DATA_WIDTH*(MAX_DIM*i+j) +: DATA_WIDTH] = a_q[i][j];
            b_col_o[DATA_WIDTH*(MAX_DIM*i+j) +: DATA_WIDTH] = b_q[i][j];
            flags_c[MAX_DIM*i+j]                            = flag_q[i][j];
         end
      end
   end

   always_comb begin
      data_out = '0;
      case (region_c)
         REG_CTRL:   data_out = BUS_WIDTH'(ctrl_q);
         REG_A:      for (int i = 0; i < MAX_DIM; i++) data_out[i*DATA_WIDTH +: DATA_WIDTH] = a_q[row_c][i];
         REG_B:      for (int i = 0; i < MAX_DIM; i++) data_out[i*DATA_WIDTH +: DATA_WIDTH] = b_q[row_c][i];
         REG_FLAGS:  data_out = BUS_WIDTH'(flags_c);
         REG_STATUS: data_out = BUS_WIDTH'({|flags_c, err_q, done_q, busy_o});
         REG_SP:     if (32'(tgt_c) < SP_NTARGETS) data_out = sp_q[tgt_c][row_c][col_c];
         default:    data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_matmul_regfile_seq.sv
// Directed and randomized checks of matmul_regfile_seq against an arithmetic reference model.
module tb_matmul_regfile_seq;

   localparam int unsigned AW  = 11;
   localparam int unsigned AW2 = 10;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          write_enable;
   logic [AW-1:0] address;
   logic [31:0]   data_in, data_out;
   logic [3:0]    pstrb_i;
   logic          done_i;
   logic [511:0]  res_i;
   logic [15:0]   ouflow_i;
   logic [127:0]  a_row_o, b_col_o;
   logic          start_bit, busy_o, irq_o, wr_err_o;

   logic           we2;
   logic [AW2-1:0] addr2;
   logic [31:0]    din2, dout2;
   logic           start2, busy2, irq2, werr2;
   logic [127:0]   unused_a2, unused_b2;

   always #5 clk_i = ~clk_i;

   matmul_regfile_seq u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .write_enable(write_enable), .address(address),
      .data_in(data_in), .pstrb_i(pstrb_i), .data_out(data_out), .done_i(done_i),
      .res_i(res_i), .ouflow_i(ouflow_i), .a_row_o(a_row_o), .b_col_o(b_col_o),
      .start_bit(start_bit), .busy_o(busy_o), .irq_o(irq_o), .wr_err_o(wr_err_o)
   );

   matmul_regfile_seq #(.SP_NTARGETS(2)) u_dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .write_enable(we2), .address(addr2),
      .data_in(din2), .pstrb_i(4'hF), .data_out(dout2), .done_i(1'b0),
      .res_i('0), .ouflow_i('0), .a_row_o(unused_a2), .b_col_o(unused_b2),
      .start_bit(start2), .busy_o(busy2), .irq_o(irq2), .wr_err_o(werr2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] m_sp [4][4][4];
   logic [7:0]  m_a  [4][4];
   logic [7:0]  m_b  [4][4];
   bit          m_flag [4][4];
   bit          m_done, m_err;
   logic [31:0] tb_res [4][4];
   logic [15:0] tb_ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] mk_addr(input int region, input int row, input int col, input int tgt);
      return {2'(tgt), 2'(col), 2'(row), 3'(region), 2'b00};
   endfunction

   function automatic logic [31:0] m_status();
      bit any;
      any = 1'b0;
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) any |= m_flag[r][j];
      return {28'd0, any, m_err, m_done, 1'b0};
   endfunction

   function automatic logic [31:0] m_flags();
      logic [31:0] f;
      f = '0;
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) f[4*r+j] = m_flag[r][j];
      return f;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 4; j++) begin
            m_a[r][j] = '0; m_b[r][j] = '0; m_flag[r][j] = 1'b0;
            for (int t = 0; t < 4; t++) m_sp[t][r][j] = '0;
         end
      m_done = 1'b0;
      m_err  = 1'b0;
   endtask

   // Whole-matrix evaluation with wide arithmetic; all reads precede all writes.
   task automatic model_wb(input logic [15:0] cw);
      longint      maxv, minv, s;
      logic [31:0] nv [4][4];
      int          tg, sr;
      bit          acc, sat, ov;
      maxv = 64'sd2147483647;
      minv = -maxv - 1;
      tg = int'(cw[3:2]); sr = int'(cw[5:4]); acc = cw[1]; sat = cw[6];
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 4; j++) begin
            s  = longint'($signed(tb_res[r][j]));
            if (acc) s += longint'($signed(m_sp[sr][r][j]));
            ov = (s > maxv) || (s < minv);
            if (ov && sat) nv[r][j] = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
            else           nv[r][j] = s[31:0];
            m_flag[r][j] = tb_ovf[4*r+j] | (acc & ov);
         end
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) m_sp[tg][r][j] = nv[r][j];
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk_i);
      write_enable = 1'b1; address = a; data_in = d; pstrb_i = s;
      @(negedge clk_i);
      write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
      @(negedge clk_i);
      address = a;
      #1 d = data_out;
   endtask

   task automatic write_ab(input int region, input int row, input logic [31:0] d, input logic [3:0] s);
      bus_write(mk_addr(region, row, 0, 0), d, s);
      for (int i = 0; i < 4; i++)
         if (s[i]) begin
            if (region == 1) m_a[row][i] = d[8*i +: 8];
            else             m_b[row][i] = d[8*i +: 8];
         end
   endtask

   task automatic write_sp(input int tgt, input int row, input int col, input logic [31:0] d);
      bus_write(mk_addr(5, row, col, tgt), d, 4'hF);
      m_sp[tgt][row][col] = d;
   endtask

   task automatic check_sp(input string tag, input int tgt);
      logic [31:0] rd;
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 4; j++) begin
            bus_read(mk_addr(5, r, j, tgt), rd);
            check($sformatf("%s_sp%0d[%0d][%0d]", tag, tgt, r, j), rd, m_sp[tgt][r][j]);
         end
   endtask

   task automatic check_ops(input string tag);
      for (int r = 0; r < 4; r++) begin
         check($sformatf("%s_a_row_o%0d", tag, r), a_row_o[32*r +: 32], {m_a[r][3], m_a[r][2], m_a[r][1], m_a[r][0]});
         check($sformatf("%s_b_col_o%0d", tag, r), b_col_o[32*r +: 32], {m_b[r][3], m_b[r][2], m_b[r][1], m_b[r][0]});
      end
   endtask

   task automatic finish_op(input logic [15:0] cw);
      int n;
      @(negedge clk_i);
      check("start_pulse_end", 32'(start_bit), 32'd0);
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) res_i[32*(4*r+j) +: 32] = tb_res[r][j];
      ouflow_i = tb_ovf;
      done_i   = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
         done_i = 1'b0;
      end while (!irq_o && n < 20);
      check("irq_latency", 32'(n), 32'd5);
      check("busy_after_wb", 32'(busy_o), 32'd0);
      model_wb(cw);
      m_done = 1'b1;
      @(negedge clk_i);
      check("irq_pulse_end", 32'(irq_o), 32'd0);
   endtask

   task automatic run_op(input logic [15:0] cw, input bit poke);
      logic [31:0] rd;
      bus_write(mk_addr(0, 0, 0, 0), {16'd0, cw}, 4'hF);
      check("start_pulse", 32'(start_bit), 32'd1);
      check("busy_on_start", 32'(busy_o), 32'd1);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (cw[7]) for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) m_flag[r][j] = 1'b0;
      if (poke) begin
         bus_write(mk_addr(1, 1, 0, 0), 32'hDEADBEEF, 4'hF);
         check("prot_wr_err", 32'(wr_err_o), 32'd1);
         check("prot_busy", 32'(busy_o), 32'd1);
         bus_read(mk_addr(1, 1, 0, 0), rd);
         check("prot_a_unchanged", rd, {m_a[1][3], m_a[1][2], m_a[1][1], m_a[1][0]});
         check("prot_wr_err_end", 32'(wr_err_o), 32'd0);
      end
      finish_op(cw);
      bus_read(mk_addr(0, 0, 0, 0), rd);
      check("ctrl_readback", rd, {16'd0, cw & 16'hFFFE});
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 2))
         0:       return $urandom;
         1:       return 32'h7FFFFF00 + 32'($urandom_range(0, 255));
         default: return 32'h80000000 + 32'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      logic [31:0] rd;
      logic [15:0] cw;
      rst_ni = 1'b0; write_enable = 1'b0; address = '0; data_in = '0; pstrb_i = '0;
      done_i = 1'b0; res_i = '0; ouflow_i = '0;
      we2 = 1'b0; addr2 = '0; din2 = '0;
      model_reset();
      #1;
      check("rst_strobes", {28'd0, start_bit, busy_o, irq_o, wr_err_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      bus_read(mk_addr(4, 0, 0, 0), rd);
      check("rst_status", rd, 32'd0);

      // Identity A, B rows of {1,2,3,4}, plain target-0 run with res=B.
      for (int r = 0; r < 4; r++) begin
         write_ab(1, r, 32'h1 << (8*r), 4'hF);
         write_ab(2, r, 32'h04030201, 4'hF);
      end
      check_ops("t1");
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) tb_res[r][j] = 32'(m_b[r][j]);
      tb_ovf = '0;
      run_op(16'h0001, 1'b0);
      check_sp("t1", 0);
      bus_read(mk_addr(5, 2, 3, 0), rd);
      check("t1_sp0_2_3", rd, 32'd4);
      bus_read(mk_addr(4, 0, 0, 0), rd);
      check("t1_status", rd, 32'h2);

      // Accumulate into SP1 with and without saturation.
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) tb_res[r][j] = '0;
      tb_res[0][0] = 32'h20;
      write_sp(1, 0, 0, 32'h7FFFFFF0);
      run_op(16'h0057, 1'b0);
      bus_read(mk_addr(5, 0, 0, 1), rd);
      check("t2_sat_value", rd, 32'h7FFFFFFF);
      bus_read(mk_addr(3, 0, 0, 0), rd);
      check("t2_sat_flag", rd & 32'h1, 32'h1);
      write_sp(1, 0, 0, 32'h7FFFFFF0);
      run_op(16'h0097, 1'b0);
      bus_read(mk_addr(5, 0, 0, 1), rd);
      check("t2_wrap_value", rd, 32'h80000010);
      bus_read(mk_addr(3, 0, 0, 0), rd);
      check("t2_wrap_flags", rd, m_flags());
      check_sp("t2", 1);

      // Byte-lane strobes.
      write_ab(1, 0, 32'h0, 4'hF);
      write_ab(1, 0, 32'hAABBCCDD, 4'b0101);
      bus_read(mk_addr(1, 0, 0, 0), rd);
      check("t3_pstrb", rd, 32'h00BB00DD);

      // Protected write while busy, then a spurious done in IDLE.
      run_op(16'h0001, 1'b1);
      check_ops("t4");
      @(negedge clk_i); done_i = 1'b1;
      @(negedge clk_i); done_i = 1'b0;
      m_err = 1'b1;
      bus_read(mk_addr(4, 0, 0, 0), rd);
      check("t4_status_err", rd, m_status());

      // Start coinciding with a spurious done: accepted, error set.
      @(negedge clk_i);
      write_enable = 1'b1; address = mk_addr(0, 0, 0, 0); data_in = 32'h0009; pstrb_i = 4'hF; done_i = 1'b1;
      @(negedge clk_i);
      write_enable = 1'b0; done_i = 1'b0;
      check("t4b_start", 32'(start_bit), 32'd1);
      m_done = 1'b0; m_err = 1'b1;
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) tb_res[r][j] = 32'(r*16 + j);
      finish_op(16'h0009);
      bus_read(mk_addr(4, 0, 0, 0), rd);
      check("t4b_status", rd, m_status());
      check_sp("t4b", 2);

      // Asynchronous reset in the middle of writeback.
      bus_write(mk_addr(0, 0, 0, 0), 32'h0001, 4'hF);
      @(negedge clk_i);
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) res_i[32*(4*r+j) +: 32] = 32'h55;
      done_i = 1'b1;
      @(negedge clk_i); done_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("t5_strobes", {28'd0, start_bit, busy_o, irq_o, wr_err_o}, 32'd0);
      check("t5_a_row_o", a_row_o[31:0], 32'd0);
      model_reset();
      bus_read(mk_addr(5, 0, 0, 0), rd);
      check("t5_sp0", rd, 32'd0);
      bus_read(mk_addr(4, 0, 0, 0), rd);
      check("t5_status", rd, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) tb_res[r][j] = 32'(100 + r - j);
      tb_ovf = 16'h8001;
      run_op(16'h0081, 1'b0);
      check_sp("t5", 0);
      bus_read(mk_addr(3, 0, 0, 0), rd);
      check("t5_flags", rd, m_flags());

      // Randomized operand writes, scratchpad preloads and operations.
      for (int it = 0; it < 8; it++) begin
         write_ab($urandom_range(1, 2), $urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)));
         for (int k = 0; k < 4; k++)
            write_sp($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rand_val());
         for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) tb_res[r][j] = rand_val();
         tb_ovf = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
         cw = {8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'b1};
         run_op(cw, 1'b0);
         check_sp($sformatf("rnd%0d", it), int'(cw[3:2]));
         bus_read(mk_addr(3, 0, 0, 0), rd);
         check($sformatf("rnd%0d_flags", it), rd, m_flags());
         bus_read(mk_addr(4, 0, 0, 0), rd);
         check($sformatf("rnd%0d_status", it), rd, m_status());
         check_ops($sformatf("rnd%0d", it));
      end

      // Two-scratchpad build: out-of-range target or source is rejected.
      @(negedge clk_i); we2 = 1'b1; addr2 = '0; din2 = 32'h000D;
      @(negedge clk_i); we2 = 1'b0;
      check("t6_no_start", 32'(start2), 32'd0);
      check("t6_wr_err", 32'(werr2), 32'd1);
      @(negedge clk_i);
      check("t6_wr_err_end", 32'(werr2), 32'd0);
      addr2 = 10'h010;
      #1 check("t6_status", dout2, 32'h4);
      @(negedge clk_i); we2 = 1'b1; addr2 = '0; din2 = 32'h0021;
      @(negedge clk_i); we2 = 1'b0;
      check("t6_src_reject", {30'd0, start2, werr2}, 32'h1);
      @(negedge clk_i); we2 = 1'b1; addr2 = '0; din2 = 32'h0005;
      @(negedge clk_i); we2 = 1'b0;
      check("t6_valid_start", {28'd0, start2, busy2, irq2, werr2}, 32'hC);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/matmul_regfile_seq.md
Name: matmul_regfile_seq

Overview:
- Parametrised next-generation register file for the matrix-multiplier accelerator, sitting between the APB slave and the matmul array.
- Holds operand matrices A/B, control/status, overflow flags and SP_NTARGETS scratchpads.
- New vs previous generation: explicit IDLE/BUSY/WRITEBACK FSM, operand write-protect while busy, row-serial writeback from a captured result buffer, and optional saturating accumulate.
- Adds sticky status/error bits and a completion interrupt pulse.

Parameters:
- BUS_WIDTH, 32, APB data width.
- DATA_WIDTH, 8, operand element width.
- MAX_DIM, 4, matrix dimension; legal range 2..BUS_WIDTH/DATA_WIDTH and at most 4.
- SP_NTARGETS, 4, scratchpad count; legal values 1, 2, 4.
- Derived: IDX_W=clog2(MAX_DIM), TGT_W=max(1,clog2(SP_NTARGETS)), LOC_ADDR_WIDTH=5+2*IDX_W+TGT_W, LANES=BUS_WIDTH/DATA_WIDTH.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- write_enable  in  1  slave write strobe, one cycle per access.
- address  in  LOC_ADDR_WIDTH  local address.
- data_in  in  BUS_WIDTH  write data.
- pstrb_i  in  LANES  byte-lane strobes for A/B writes.
- data_out  out  BUS_WIDTH  combinational read data.
- done_i  in  1  multiplier result-valid pulse.
- res_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  flattened results, element (i,j) at BUS_WIDTH*(MAX_DIM*i+j).
- ouflow_i  in  MAX_DIM*MAX_DIM  per-element overflow flags from the processing elements.
- a_row_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  flattened matrix A to the multiplier.
- b_col_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  flattened matrix B to the multiplier.
- start_bit  out  1  one-cycle start pulse.
- busy_o  out  1  high in BUSY or WRITEBACK.
- irq_o  out  1  one-cycle pulse when writeback completes.
- wr_err_o  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Address decode:
  - region = address[4:2]: 0 control, 1 A row, 2 B row, 3 flags, 4 status, 5 SP; other regions read 0 and ignore writes.
  - row = address[5+:IDX_W]; col = address[5+IDX_W+:IDX_W]; tgt = address[5+2*IDX_W+:TGT_W].
  - A/B region is row-addressed: lane i holds element [row][i]; lanes with i >= MAX_DIM read 0.
- Control register, 16 bits:
  - [0] start, [1] accumulate, [3:2] target SP, [5:4] source SP, [6] saturate, [7] clear-flags-on-start; [15:8] reserved, read as written.
  - Bit 0 is never stored: it always reads 0.
- Status register, read-only: [0] busy, [1] done (sticky), [2] error (sticky), [3] any-flag. Writing control with bit0=1 clears done and error.
- Reset (rst_ni low, asynchronous):
  - All matrices, flags, SPs, control, status and the result buffer go to 0; FSM to IDLE.
  - start_bit, irq_o, wr_err_o, busy_o are 0 immediately.
  - Applies even mid-BUSY or mid-WRITEBACK.
- FSM:
  - IDLE: a write to control stores it. If data_in[0]=1 and the target/source index < SP_NTARGETS, start_bit pulses the next cycle and the FSM goes to BUSY. An out-of-range index sets error, pulses wr_err_o and stays IDLE.
  - BUSY: wait for done_i. On done_i, capture res_i and ouflow_i into the result buffer, row counter=0, go to WRITEBACK.
  - WRITEBACK: one row per cycle, row r computed as:
    - SP[tgt][r][j] <= (accumulate ? SP[src][r][j] : 0) + buf[r][j], as a signed BUS_WIDTH add.
    - flag[r][j] <= buf_ouflow | (accumulate & signed_overflow).
    - On overflow with saturate=1, the result clamps to the max/min signed value; with saturate=0 it wraps.
    - After row MAX_DIM-1: set done, pulse irq_o, return to IDLE. Latency from done_i to irq_o is MAX_DIM+1 cycles.
- Protection: any write to control, A or B while busy is dropped and pulses wr_err_o; reads are always allowed.
- done_i in IDLE or WRITEBACK is ignored and sets error.
- Control write with start in IDLE in the same cycle as a spurious done_i: start is accepted and error is set.
- Reads during WRITEBACK return the current SP contents: rows not yet written show old values.
- tgt==src with accumulate: each element is read before it is written in the same cycle, so old+res is correct.
- clear-flags-on-start: all flags are cleared in the cycle start is accepted.
- a_row_o/b_col_o are continuous copies of A/B; they are frozen during busy by the write protection.

Decomposition:
- Shared package matmul_rf_pkg:
  - Region codes and control/status bit indices.
  - State encoding IDLE/BUSY/WRITEBACK.
  - Saturation max/min constant function.
- One natural sub-module: matmul_rf_sat_add, the combinational signed add with overflow detect and optional clamp; instantiate it MAX_DIM times for row-parallel writeback.

Test Plan:
1. Load A=identity, B rows {1,2,3,4}; control=0x0001 (target 0, no accumulate); drive done_i with res=B and ouflow=0 -> start_bit one cycle after the write, SP0 equals B, irq_o 5 cycles after done_i, status=0x2.
2. SP1[0][0]=0x7FFFFFF0; accumulate src=tgt=1, saturate=1; res[0][0]=0x20 -> SP1[0][0]=0x7FFFFFFF, flag bit0=1. Repeat with saturate=0 -> 0x80000010, flag=1.
3. Write A row 0 with pstrb=4'b0101, data 0xAABBCCDD -> row reads 0x00BB00DD from a zero start.
4. Write to A while BUSY -> wr_err_o pulse, A unchanged, busy_o stays 1. A done_i pulse in IDLE -> status error=1.
5. Assert rst_ni low during WRITEBACK row 2 -> all outputs 0 asynchronously, SPs 0, FSM IDLE, a new start works normally.
6. SP_NTARGETS=2 build: control target=3 with start -> no start_bit, wr_err_o pulse, status error=1.
